uart_tx_buffered: RTL and testbench

//   Buffered 8N1 UART transmitter that serialises result bytes from the sum/latch datapath onto uart_txd.

---
 rtl/sumlatch_uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 81 ++++++++
 rtl/uart_tx_buffered.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumlatch_uart_pkg.sv
// Shared definitions for the sum/latch UART transmit path.
//   uart_tx_state_t : transmitter FSM encoding
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   clks_per_bit()  : clock cycles per serial bit (integer divide)
package sumlatch_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   push, din    : write request and byte (ignored while full)
//   pop, dout    : read request (ignored while empty); dout shows the head
//   full, empty  : registered status flags
//   level        : registered number of stored bytes (0..DEPTH)
module uart_tx_fifo
  import sumlatch_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_n_s;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next fill level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_n_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_n_s = level_r + LVL_ONE;
      2'b01:   level_n_s = level_r - LVL_ONE;
      default: level_n_s = level_r;
    endcase
  end

  // Pointers, level and flags; flags are registered from the next level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= LVL_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      level_r <= level_n_s;
      full_r  <= (level_n_s == LVL_FULL);
      empty_r <= (level_n_s == LVL_ZERO);
    end
  end

  // Storage array; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = level_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes accepted over valid/ready are queued
// in a small FIFO and framed LSB-first on uart_txd with no gap between
// back-to-back frames.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   tx_data, tx_valid     : producer byte and request
//   tx_ready              : FIFO not full (registered flag)
//   uart_txd              : registered serial line, idle high
//   uart_tx_busy          : frame in flight or bytes waiting (registered)
//   fifo_level            : bytes waiting in the FIFO (not counting the shifter)
module uart_tx_buffered
  import sumlatch_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t state_r, state_n_s;
  logic [CW-1:0]  cnt_r, cnt_n_s;
  logic [BW-1:0]  bit_idx_r, bit_idx_n_s;
  logic [7:0]     shift_r, shift_n_s;
  logic           txd_r, txd_n_s;
  logic           busy_r, busy_n_s;
  logic           pop_s;
  logic           last_s;
  logic [7:0]     fifo_head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // Next-state logic: baud counting, bit sequencing and FIFO pops.
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    bit_idx_n_s = bit_idx_r;
    shift_n_s   = shift_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n_s = CNT_ZERO;
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_n_s = fifo_head_s;
          state_n_s = START;
        end else begin
          state_n_s = IDLE;
        end
      end
      START: begin
        if (last_s) begin
          cnt_n_s     = CNT_ZERO;
          bit_idx_n_s = BIT_ZERO;
          state_n_s   = DATA;
        end else begin
          cnt_n_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (last_s) begin
          cnt_n_s   = CNT_ZERO;
          shift_n_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == BIT_LAST) begin
            state_n_s = STOP;
          end else begin
            bit_idx_n_s = bit_idx_r + BIT_ONE;
          end
        end else begin
          cnt_n_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (last_s) begin
          cnt_n_s = CNT_ZERO;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            shift_n_s = fifo_head_s;
            state_n_s = START;
          end else begin
            state_n_s = IDLE;
          end
        end else begin
          cnt_n_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
  end

  // Line level and busy decoded from the current state; registered one
  // cycle behind the state so every frame phase keeps its full length.
  always_comb begin
    busy_n_s = (state_r != IDLE) || !fifo_empty_s;
    case (state_r)
      IDLE:    txd_n_s = 1'b1;
      START:   txd_n_s = 1'b0;
      DATA:    txd_n_s = shift_r[0];
      STOP:    txd_n_s = 1'b1;
      default: txd_n_s = 1'b1;
    endcase
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= BIT_ZERO;
      shift_r   <= 8'h00;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      bit_idx_r <= bit_idx_n_s;
      shift_r   <= shift_n_s;
      txd_r     <= txd_n_s;
      busy_r    <= busy_n_s;
    end
  end

  assign tx_ready     = !fifo_full_s;
  assign uart_txd     = txd_r;
  assign uart_tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT = 8, FIFO depth 4.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_buffered #(
    .CLK_FREQ   (8),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp start bits.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent line receiver: samples mid-bit, records bytes, stop bits and start times.
  logic [7:0] rx_q[$];
  bit         rx_stop_q[$];
  int         rx_t[$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_stop = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (uart_txd === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 12 && rx_cnt <= 68 && (rx_cnt % 8) == 4)
        rx_sh <= {uart_txd, rx_sh[7:1]};
      if (rx_cnt == 76) rx_stop <= uart_txd;
      if (rx_cnt == 79) begin
        rx_q.push_back(rx_sh);
        rx_stop_q.push_back(rx_stop);
        rx_act <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " txd"},   32'(uart_txd),     32'd1);
    chk({tag, " busy"},  32'(uart_tx_busy), 32'd0);
    chk({tag, " ready"}, 32'(tx_ready),     32'd1);
    chk({tag, " level"}, 32'(fifo_level),   32'd0);
  endtask

  // Checks txd on every cycle of one 80-cycle frame, starting at the start-bit edge.
  task automatic frame_check(input string tag, input logic [7:0] b);
    logic exp;
    for (int i = 0; i < 80; i++) begin
      if (i < 8)        exp = 1'b0;
      else if (i >= 72) exp = 1'b1;
      else              exp = b[(i - 8) / 8];
      chk($sformatf("%s txd c%0d", tag, i), 32'(uart_txd), 32'(exp));
      if (i == 79) chk({tag, " busy last"}, 32'(uart_tx_busy), 32'd1);
      tick();
    end
  endtask

  task automatic wait_rx(input string tag, input int n, input int bound);
    int k = 0;
    while (rx_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk({tag, " rx count"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (uart_tx_busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    chk({tag, " idle"}, 32'(uart_tx_busy), 32'd0);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_stop_q.delete();
    rx_t.delete();
  endtask

  initial begin
    int idx;
    int guard;
    logic acc;

    // 1: reset state, during and after reset, including a mid-frame reset
    repeat (3) tick();
    chk_reset_state("t1 in reset");
    reset = 1'b0;
    tick();
    chk_reset_state("t1 released");
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (20) tick();
    chk("t1 running busy", 32'(uart_tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_state("t1 mid reset");
    tick();
    chk_reset_state("t1 held");
    reset = 1'b0;
    tick();
    chk_reset_state("t1 after");
    repeat (3) tick();
    rx_clear();

    // 2: single 0xA5 frame with exact latency and busy timing
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("t2 level", 32'(fifo_level), 32'd1);
    tick();
    chk("t2 txd edge1", 32'(uart_txd), 32'd1);
    tick();
    chk("t2 busy", 32'(uart_tx_busy), 32'd1);
    frame_check("t2", 8'hA5);
    chk("t2 busy fell", 32'(uart_tx_busy), 32'd0);
    chk("t2 txd idle", 32'(uart_txd), 32'd1);
    chk("t2 rx byte", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h000000A5);
    rx_clear();

    // 3: stream 0x01..0x06 with tx_valid held
    idx = 0; guard = 0;
    tx_valid = 1'b1;
    while (idx < 6 && guard < 2000) begin
      tx_data = 8'(idx + 1);
      acc = tx_ready;
      tick();
      guard++;
      if (acc) begin
        idx++;
        if (idx == 5) begin
          chk("t3 level full", 32'(fifo_level), 32'd4);
          chk("t3 ready low", 32'(tx_ready), 32'd0);
        end
      end
    end
    tx_valid = 1'b0;
    chk("t3 accepted", 32'(idx), 32'd6);
    wait_rx("t3", 6, 800);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      chk($sformatf("t3 byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
      chk($sformatf("t3 stop%0d", i), 32'(rx_stop_q[i]), 32'd1);
    end
    for (int i = 0; i < 5 && i + 1 < rx_t.size(); i++)
      chk($sformatf("t3 gap%0d", i), 32'(rx_t[i + 1] - rx_t[i]), 32'd80);
    wait_idle("t3", 200);
    rx_clear();

    // 4: push while full is dropped
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(8'h11 + i);
      tick();
    end
    tx_data = 8'h77;
    chk("t4 ready low", 32'(tx_ready), 32'd0);
    tick();
    tx_valid = 1'b0;
    chk("t4 level kept", 32'(fifo_level), 32'd4);
    wait_rx("t4", 5, 800);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("t4 byte%0d", i), 32'(rx_q[i]), 32'(8'h11 + i));
    wait_idle("t4", 200);
    repeat (20) tick();
    chk("t4 no 0x77", 32'(rx_q.size()), 32'd5);
    rx_clear();

    // 5: reset during DATA bit 3 of 0x0F, then a clean 0x3C frame
    tx_data = 8'h0F; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("t5 start", 32'(uart_txd), 32'd0);
    repeat (34) tick();
    chk("t5 bit3", 32'(uart_txd), 32'd1);
    chk("t5 busy pre", 32'(uart_tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_state("t5 reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_reset_state("t5 released");
    repeat (100) tick();
    chk("t5 aborted", 32'(rx_q.size()), 32'd0);
    chk("t5 still idle", 32'(uart_txd), 32'd1);
    rx_clear();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_rx("t5", 1, 200);
    chk("t5 byte", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h0000003C);
    chk("t5 stop", 32'(rx_stop_q.size() > 0 ? rx_stop_q[0] : 1'b0), 32'd1);
    wait_idle("t5", 200);
    rx_clear();

    // 6: 0x00 then 0xFF back-to-back, cycle-exact line check
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    frame_check("t6a", 8'h00);
    frame_check("t6b", 8'hFF);
    chk("t6 busy fell", 32'(uart_tx_busy), 32'd0);
    chk("t6 txd idle", 32'(uart_txd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
